// File: rtl/mul_arb.sv
// Round-robin arbiter sharing one external multiplier among NREQ requesters,
// with a single operation in flight from grant to returned product.
//
// Handshakes: every channel (req, m_ab, m_p, rsp) transfers on a rising edge
// where its valid and ready are both high; a source holds valid and data
// stable until that edge, and ready may depend on valid in the same cycle.
module mul_arb #(
  parameter int bW   = 8,
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0][bW-1:0]   req_a,
  input  logic [NREQ-1:0][bW-1:0]   req_b,
  input  logic [NREQ-1:0]           req_vld,
  output logic [NREQ-1:0]           req_rdy,
  output logic [2*bW-1:0]           rsp_prod,
  output logic [NREQ-1:0]           rsp_vld,
  input  logic [NREQ-1:0]           rsp_rdy,
  output logic [bW-1:0]             m_a,
  output logic [bW-1:0]             m_b,
  output logic                      m_ab_vld,
  input  logic                      m_ab_rdy,
  input  logic [2*bW-1:0]           m_prod,
  input  logic                      m_p_vld,
  output logic                      m_p_rdy,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy,
  output logic [15:0]               done_cnt,
  output logic [1:0]                fsm_state
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   ptr;
  logic [bW-1:0]   a_q, b_q;
  logic [2*bW-1:0] prod_q;
  logic            take, cap, ret;
  logic            gnt_any;
  logic [OW-1:0]   gnt_idx;
  int              pos;

  // Walk downward so the last hit wins: that is the first valid at or after ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    pos     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % NREQ;
      if (req_vld[pos]) begin
        gnt_any = 1'b1;
        gnt_idx = OW'(pos);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_rdy   = '0;
    take      = 1'b0;
    cap       = 1'b0;
    ret       = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          req_rdy[gnt_idx] = rst;
          take             = 1'b1;
          state_nxt        = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ab_rdy) state_nxt = WAIT;
      end
      WAIT: begin
        if (m_p_vld) begin
          cap       = 1'b1;
          state_nxt = RETURN;
        end
      end
      RETURN: begin
        if (rsp_rdy[owner]) begin
          ret       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      done_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        a_q   <= req_a[gnt_idx];
        b_q   <= req_b[gnt_idx];
        owner <= gnt_idx;
      end
      if (cap) prod_q <= m_prod;
      if (ret) begin
        ptr      <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
        done_cnt <= done_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    rsp_vld = '0;
    if (state == RETURN) rsp_vld[owner] = 1'b1;
  end

  assign m_a       = a_q;
  assign m_b       = b_q;
  assign m_ab_vld  = (state == ISSUE);
  assign m_p_rdy   = (state == WAIT);
  assign rsp_prod  = prod_q;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_mul_arb.sv
// Bench for mul_arb: randomized requesters and multiplier model, with a
// scoreboard of expected (owner, product) pairs checked by a negedge monitor.
module tb_mul_arb;
  localparam int BW   = 8;
  localparam int NREQ = 4;
  localparam int IW   = 2;
  localparam int PW   = 2 * BW;
  localparam int EW   = IW + PW;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [NREQ-1:0][BW-1:0] req_a = '0;
  logic [NREQ-1:0][BW-1:0] req_b = '0;
  logic [NREQ-1:0]         req_vld = '0;
  logic [NREQ-1:0]         req_rdy;
  logic [PW-1:0]           rsp_prod;
  logic [NREQ-1:0]         rsp_vld;
  logic [NREQ-1:0]         rsp_rdy = '0;
  logic [BW-1:0]           m_a, m_b;
  logic                    m_ab_vld;
  logic                    m_ab_rdy = 1'b0;
  logic [PW-1:0]           m_prod = '0;
  logic                    m_p_vld = 1'b0;
  logic                    m_p_rdy;
  logic [IW-1:0]           owner;
  logic                    busy;
  logic [15:0]             done_cnt;
  logic [1:0]              fsm_state;

  always #5 clk = ~clk;

  mul_arb #(.bW(BW), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_vld(req_vld),
    .req_rdy(req_rdy), .rsp_prod(rsp_prod), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .m_a(m_a), .m_b(m_b), .m_ab_vld(m_ab_vld), .m_ab_rdy(m_ab_rdy),
    .m_prod(m_prod), .m_p_vld(m_p_vld), .m_p_rdy(m_p_rdy), .owner(owner),
    .busy(busy), .done_cnt(done_cnt), .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int rsp_count = 0;
  logic [EW-1:0] exp_q[$];

  // Environment knobs for the multiplier model.
  bit ab_force = 1'b0;
  int ab_hold  = 0;
  int lat_lo   = 0;
  int lat_hi   = 3;

  // Values sampled by the monitor for the multiplier model.
  bit          ab_vld_s = 1'b0, ab_hs_s = 1'b0, p_hs_s = 1'b0;
  logic [PW-1:0] ab_prod_s = '0;

  int model_ptr = 0, model_done = 0, mon_g, mon_idx;
  logic [NREQ-1:0] exp_mask;
  logic [EW-1:0]   mon_e;
  bit              prev_rsp_hold = 1'b0, prev_ab_stall = 1'b0;
  logic [NREQ-1:0] prev_rsp_vld;
  logic [PW-1:0]   prev_rsp_prod;
  logic [BW-1:0]   prev_ma, prev_mb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return BW'($urandom);
    endcase
  endfunction

  // Monitor and scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        model_ptr = 0; model_done = 0;
        ab_vld_s = 0; ab_hs_s = 0; p_hs_s = 0;
        prev_rsp_hold = 0; prev_ab_stall = 0;
        check("reset_ctrl", {done_cnt, owner, req_rdy, rsp_vld, m_ab_vld, m_p_rdy, busy}, '0);
        check("reset_data", {rsp_prod, m_a, m_b}, '0);
      end else begin
        if (prev_rsp_hold) check("rsp_hold", {rsp_vld, rsp_prod}, {prev_rsp_vld, prev_rsp_prod});
        if (prev_ab_stall) check("ab_hold", {m_ab_vld, m_a, m_b}, {1'b1, prev_ma, prev_mb});
        if (req_rdy != '0) begin
          mon_g = -1;
          for (int k = NREQ - 1; k >= 0; k--)
            if (req_vld[(model_ptr + k) % NREQ]) mon_g = (model_ptr + k) % NREQ;
          exp_mask = '0;
          if (mon_g >= 0) exp_mask[mon_g] = 1'b1;
          check("grant", req_rdy, exp_mask);
          for (int i = 0; i < NREQ; i++)
            if (req_rdy[i] && req_vld[i])
              exp_q.push_back({IW'(i), PW'(req_a[i]) * PW'(req_b[i])});
        end
        if (rsp_vld != '0) begin
          check("rsp_onehot", $countones(rsp_vld), 1);
          mon_idx = 0;
          for (int i = 0; i < NREQ; i++) if (rsp_vld[i]) mon_idx = i;
          check("owner_port", owner, mon_idx);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: rsp_vld=0x%0h, expected nothing outstanding", rsp_vld);
          end else if (rsp_rdy[mon_idx]) begin
            mon_e = exp_q.pop_front();
            check("rsp_idx", mon_idx, mon_e[EW-1:PW]);
            check("rsp_prod", rsp_prod, mon_e[PW-1:0]);
            check("done_cnt", done_cnt, 16'(model_done));
            model_done++;
            model_ptr = (mon_idx + 1) % NREQ;
            rsp_count++;
          end
          prev_rsp_hold = !rsp_rdy[mon_idx];
        end else begin
          prev_rsp_hold = 1'b0;
        end
        prev_rsp_vld  = rsp_vld;
        prev_rsp_prod = rsp_prod;
        prev_ab_stall = m_ab_vld && !m_ab_rdy;
        prev_ma = m_a;
        prev_mb = m_b;
        ab_vld_s  = m_ab_vld;
        ab_hs_s   = m_ab_vld && m_ab_rdy;
        ab_prod_s = PW'(m_a) * PW'(m_b);
        p_hs_s    = m_p_vld && m_p_rdy;
      end
    end
  end

  // Multiplier model: random acceptance, random latency, garbage product when idle.
  bit            mul_pend = 1'b0;
  int            mul_lat  = 0;
  logic [PW-1:0] mul_held = '0;
  initial begin
    forever begin
      tick();
      if (!rst) begin
        mul_pend = 0; m_p_vld = 0; m_ab_rdy = 0; m_prod = PW'($urandom);
      end else begin
        if (p_hs_s) begin m_p_vld = 0; mul_pend = 0; end
        if (ab_hs_s) begin
          mul_pend = 1; mul_lat = $urandom_range(lat_lo, lat_hi); mul_held = ab_prod_s;
        end
        if (mul_pend) begin
          m_ab_rdy = 0;
          if (!m_p_vld) begin
            if (mul_lat == 0) m_p_vld = 1; else mul_lat--;
          end
        end else if (ab_force) begin
          if (ab_vld_s && ab_hold > 0) ab_hold--;
          m_ab_rdy = (ab_hold == 0);
        end else begin
          m_ab_rdy = ($urandom_range(0, 3) != 0);
        end
        m_prod = m_p_vld ? mul_held : PW'($urandom);
      end
    end
  end

  task automatic single(input int idx, input logic [BW-1:0] a, input logic [BW-1:0] b,
                        output logic [PW-1:0] prod, output int pulses, output int gcyc,
                        output int abcyc, output int abn, output int stalls, output int rcyc,
                        output bit ab_stable);
    bit drop;
    prod = '0; pulses = 0; gcyc = -1; abcyc = -1; abn = 0; stalls = 0; rcyc = -1; ab_stable = 1;
    tick();
    req_a[idx] = a; req_b[idx] = b; req_vld[idx] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_rdy[idx]) begin pulses++; gcyc = c; end
      if (m_ab_vld) begin
        abn++;
        if (abcyc < 0) abcyc = c;
        if (!m_ab_rdy) stalls++;
        if (m_a !== a || m_b !== b) ab_stable = 0;
      end
      if (rsp_vld[idx] && rsp_rdy[idx]) begin prod = rsp_prod; rcyc = c; end
      drop = req_rdy[idx];
      tick();
      if (drop) req_vld[idx] = 1'b0;
      if (rcyc >= 0) break;
    end
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 0;
    tick();
    req_vld = '0; rsp_rdy = '1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    check(name, ok, 1);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [PW-1:0]   prod, hold_prod;
    int              pulses, gcyc, abcyc, abn, stalls, rcyc, bad, r0, ng;
    bit              ab_stable, seen, drop;
    logic [NREQ-1:0] hs;
    logic [BW-1:0]   a1, b1;
    int              order[6];

    do_reset();
    rsp_rdy = '1;

    // Single request, multiplier always ready with zero latency.
    ab_force = 1; ab_hold = 0; lat_lo = 0; lat_hi = 0;
    single(2, 8'd13, 8'd11, prod, pulses, gcyc, abcyc, abn, stalls, rcyc, ab_stable);
    check("t1_rsp_seen", rcyc >= 0, 1);
    check("t1_req_pulses", pulses, 1);
    check("t1_ab_after_grant", abcyc - gcyc, 1);
    check("t1_min_latency", rcyc - gcyc, 3);
    check("t1_prod", prod, 16'd143);
    @(negedge clk);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_idle_gap", busy, 0);

    // Maximum operands, random multiplier timing.
    ab_force = 0; lat_lo = 0; lat_hi = 3;
    single(3, 8'hFF, 8'hFF, prod, pulses, gcyc, abcyc, abn, stalls, rcyc, ab_stable);
    check("t4_rsp_seen", rcyc >= 0, 1);
    check("t4_prod", prod, 16'hFE01);

    // Multiplier backpressure for five ISSUE cycles.
    ab_force = 1; ab_hold = 5;
    a1 = BW'($urandom); b1 = BW'($urandom);
    single(0, a1, b1, prod, pulses, gcyc, abcyc, abn, stalls, rcyc, ab_stable);
    check("t5_stalls", stalls, 5);
    check("t5_ab_cycles", abn, 6);
    check("t5_ab_stable", ab_stable, 1);
    check("t5_prod", prod, PW'(a1) * PW'(b1));
    ab_force = 0;

    // Randomized traffic.
    r0 = rsp_count;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs = req_vld & req_rdy;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) req_vld[i] = 1'b0;
        else if (req_vld[i] && $urandom_range(0, 15) == 0) req_vld[i] = 1'b0;
        if (!req_vld[i] && !hs[i] && $urandom_range(0, 2) == 0) begin
          req_vld[i] = 1'b1; req_a[i] = pick(); req_b[i] = pick();
        end
      end
      rsp_rdy = NREQ'($urandom);
    end
    drain("rand_drain");
    check("rand_progress", (rsp_count - r0) > 50, 1);

    // Reset while waiting on the multiplier.
    lat_lo = 12; lat_hi = 12;
    tick();
    req_a[3] = BW'($urandom); req_b[3] = BW'($urandom); req_vld[3] = 1'b1;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (m_p_rdy) begin seen = 1; break; end
      drop = req_rdy[3];
      tick();
      if (drop) req_vld[3] = 1'b0;
    end
    check("t6_reach_wait", seen, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_busy", busy, 0);
    check("t6_async_cnt", done_cnt, 0);
    req_vld = '0;
    tick(); tick();
    rst = 1'b1;
    lat_lo = 0; lat_hi = 3;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rsp_vld != '0 || busy) bad++;
      tick();
    end
    check("t6_no_rsp", bad, 0);
    req_a[1] = pick(); req_b[1] = pick(); req_a[3] = pick(); req_b[3] = pick();
    req_vld = 4'b1010;
    @(negedge clk);
    check("t6_first_grant", req_rdy, 4'b0010);
    drain("t6_drain");

    // All requesters valid from reset: strict rotation.
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin req_a[i] = pick(); req_b[i] = pick(); end
    req_vld = '1; rsp_rdy = '1;
    repeat (2) tick();
    rst = 1'b1;
    ng = 0;
    for (int c = 0; c < 200 && ng < 6; c++) begin
      @(negedge clk);
      hs = req_vld & req_rdy;
      for (int i = 0; i < NREQ; i++) if (hs[i]) begin order[ng] = i; ng++; end
      tick();
      for (int i = 0; i < NREQ; i++) if (hs[i]) begin req_a[i] = pick(); req_b[i] = pick(); end
    end
    check("t2_grants", ng, 6);
    check("t2_order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0],
                       order[4][3:0], order[5][3:0]}, 24'h012301);
    drain("t2_drain");

    // Response stall by owner 1 blocks all other traffic.
    do_reset();
    rsp_rdy = 4'b1101;
    a1 = pick(); b1 = pick();
    req_a[1] = a1; req_b[1] = b1; req_vld = 4'b0010;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rsp_vld[1]) begin seen = 1; break; end
      drop = req_rdy[1];
      tick();
      if (drop) req_vld[1] = 1'b0;
    end
    check("t3_rsp_seen", seen, 1);
    hold_prod = rsp_prod;
    check("t3_prod", hold_prod, PW'(a1) * PW'(b1));
    tick();
    for (int i = 0; i < NREQ; i++) begin req_a[i] = pick(); req_b[i] = pick(); end
    req_vld = 4'b1101;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_vld !== 4'b0010 || rsp_prod !== hold_prod || req_rdy !== '0 || m_ab_vld !== 1'b0)
        bad++;
      tick();
    end
    check("t3_stall_block", bad, 0);
    rsp_rdy = '1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_rdy != '0) begin seen = 1; break; end
      tick();
    end
    check("t3_next_grant", req_rdy, 4'b0100);
    drain("t3_drain");

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_arb.md
MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 SHALL have parameter bW, default 8, the operand width of the shared multiplier.
REQ-002 SHALL have parameter NREQ, default 4, the number of requesters (2..8).
REQ-003 SHALL have port clk  input  1  the single clock; all flops are rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_a  input  NREQ x bW  operand a per requester.
REQ-006 SHALL have port req_b  input  NREQ x bW  operand b per requester.
REQ-007 SHALL have port req_vld  input  NREQ  the requester's operands are valid.
REQ-008 SHALL have port req_rdy  output  NREQ  the operands are accepted this cycle.
REQ-009 SHALL have port rsp_prod  output  2*bW  the product returned to the owner.
REQ-010 SHALL have port rsp_vld  output  NREQ  one-hot; the product is valid for that requester.
REQ-011 SHALL have port rsp_rdy  input  NREQ  the requester accepts the product.
REQ-012 SHALL have port m_a  output  bW  multiplier operand a.
REQ-013 SHALL have port m_b  output  bW  multiplier operand b.
REQ-014 SHALL have port m_ab_vld  output  1  to the multiplier.
REQ-015 SHALL have port m_ab_rdy  input  1  from the multiplier.
REQ-016 SHALL have port m_prod  input  2*bW  product from the multiplier.
REQ-017 SHALL have port m_p_vld  input  1  from the multiplier.
REQ-018 SHALL have port m_p_rdy  output  1  to the multiplier.
REQ-019 SHALL have port owner  output  $clog2(NREQ)  index of the current or last granted requester.
REQ-020 SHALL have port busy  output  1  high in every state except IDLE.
REQ-021 SHALL have port done_cnt  output  16  count of completed operations, wrapping at 16 bits.

Function
REQ-022 SHALL implement the FSM states IDLE, ISSUE, WAIT and RETURN, with exactly one operation outstanding at a time.
REQ-023 In IDLE, SHALL grant round-robin: the first asserted req_vld searching from ptr upward, wrapping NREQ-1 to 0.
REQ-024 In IDLE with any req_vld high, SHALL assert req_rdy[g] for the granted requester only (one-hot) for one cycle, latch req_a[g] and req_b[g], set owner=g, and go to ISSUE.
REQ-025 In ISSUE, SHALL drive m_ab_vld=1 with the latched operands until the cycle m_ab_rdy=1, then go to WAIT; the operands SHALL stay stable while m_ab_vld is high.
REQ-026 In WAIT, SHALL drive m_p_rdy=1; in the cycle m_p_vld=1 it SHALL capture m_prod and go to RETURN.
REQ-027 m_p_rdy SHALL be 0 in all states other than WAIT.
REQ-028 In RETURN, SHALL hold rsp_vld[owner]=1 and rsp_prod stable until rsp_rdy[owner]=1.
REQ-029 On that RETURN handshake, SHALL set ptr=(owner+1) mod NREQ, increment done_cnt, and go to IDLE.
REQ-030 rsp_rdy bits of non-owners SHALL be ignored.
REQ-031 A stalled RETURN (rsp_rdy low) SHALL block all new grants; no request SHALL be dropped or reordered.
REQ-032 Minimum latency from the req handshake to rsp_vld SHALL be 3 cycles plus the multiplier latency; an IDLE cycle SHALL separate consecutive operations.
REQ-033 rsp_prod SHALL be the exact unsigned 2*bW-bit product a*b, with no truncation.
REQ-034 Requesters SHALL hold req_vld and operands until req_rdy; a req_vld deasserted before grant SHALL simply not be granted.
REQ-035 m_prod SHALL be sampled only on the m_p_vld&&m_p_rdy cycle.
REQ-036 done_cnt SHALL wrap from 16'hFFFF to 0.

Reset
REQ-037 While rst=0, SHALL force state=IDLE, ptr=0, owner=0, done_cnt=0, latched operands=0, product register=0, and all outputs low, including req_rdy, which SHALL be gated by rst.
REQ-038 rst asserted mid-operation SHALL abandon the operation immediately, with no rsp_vld.
REQ-039 The first grant after release of rst SHALL use the search order starting at 0.

Verification
REQ-040 Bench SHALL cover a single request with bW=8: req 2 sends a=8'd13, b=8'd11 -> exactly one req_rdy[2] pulse, m_ab_vld one cycle later, then rsp_vld[2] with rsp_prod=16'd143, and done_cnt=1.
REQ-041 Bench SHALL cover all four requesters held valid continuously from reset -> grant order 0,1,2,3,0,1, and each rsp_vld goes to the matching owner.
REQ-042 Bench SHALL cover an rsp_rdy stall: owner 1 holds rsp_rdy=0 for 20 cycles -> rsp_vld[1] and rsp_prod stay stable, no req_rdy pulses, and m_ab_vld=0 throughout.
REQ-043 Bench SHALL cover maximum operands a=b=8'hFF -> rsp_prod=16'hFE01.
REQ-044 Bench SHALL cover a multiplier backpressure stall: m_ab_rdy held 0 for 5 cycles in ISSUE -> m_a and m_b unchanged, and the handshake completes on the first m_ab_rdy=1 cycle.
REQ-045 Bench SHALL cover reset in WAIT: rst=0 pulse -> busy=0 and done_cnt=0 asynchronously, no rsp_vld afterwards, and the next grant goes to the lowest-index valid requester.
